// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle SLL/SRL/SRA(/ROR) controller.
// A shift is done as power-of-two steps (1,2,4,8,16), one per clock, LSB-first. Only the
// set bits of the shift amount take a step, so each cycle needs just one mux level.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (op 11 = rotate right; otherwise op 11 = SRL).
module shift_sequencer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} t_state;
  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} t_op;

  // One step by a fixed power-of-two amount. With a constant amt each op is pure wiring.
  function automatic logic [DATA_W-1:0] f_shift_const(input logic [DATA_W-1:0] a,
                                                       input t_op op,
                                                       input int unsigned amt);
    logic [DATA_W-1:0] r;
    case (op)
      OP_SLL:  r = a << amt;
      OP_SRL:  r = a >> amt;
      OP_SRA:  r = $signed(a) >>> amt;
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROR:  r = (a >> amt) | (a << (DATA_W - amt));
`else
      OP_ROR:  r = a >> amt;
`endif
      default: r = a;
    endcase
    return r;
  endfunction

  t_state             r_state, w_state_nxt;
  t_op                r_op, w_op_nxt;
  logic [DATA_W-1:0]  r_acc, w_acc_nxt;
  logic [DATA_W-1:0]  r_out, w_out_nxt;
  logic [SHAMT_W-1:0] r_rem, w_rem_nxt;
  logic [SHAMT_W-1:0] w_low;
  logic [DATA_W-1:0]  w_step;
  logic               w_accept;

  // Isolate the lowest set bit of the remaining amount; its one-hot value is the step size.
  always_comb begin
    w_low = r_rem & (~r_rem + SHAMT_W'(1));
  end

  // Select the single constant-amount shift picked by the one-hot step bit.
  always_comb begin
    w_step = r_acc;
    for (int unsigned i = 0; i < SHAMT_W; i++) begin
      if (w_low[i]) w_step = f_shift_const(r_acc, r_op, 32'(1) << i);
    end
  end

  // Next-state, datapath next values and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_acc_nxt   = r_acc;
    w_rem_nxt   = r_rem;
    w_out_nxt   = r_out;
    in_ready    = (r_state == S_IDLE) && !reset;
    out_valid   = (r_state == S_DONE);
    busy        = (r_state != S_IDLE);
    out_data    = r_out;
    w_accept    = in_valid && in_ready;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc_nxt = in_data;
          w_rem_nxt = in_shamt;
          w_op_nxt  = t_op'(in_op);
          if (in_shamt == '0) begin
            w_state_nxt = S_DONE;
            w_out_nxt   = in_data;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        w_acc_nxt = w_step;
        w_rem_nxt = r_rem & ~w_low;
        if ((r_rem & ~w_low) == '0) begin
          w_state_nxt = S_DONE;
          w_out_nxt   = w_step;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_SLL;
      r_acc   <= '0;
      r_rem   <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_acc   <= w_acc_nxt;
      r_rem   <= w_rem_nxt;
      r_out   <= w_out_nxt;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer (honours SHIFT_SEQ_ROTATE_EN for op 11).
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic [31:0] data;
    int unsigned lat;
  } exp_t;
  exp_t sb[$];

  shift_sequencer #(.DATA_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written from the operation definitions, not the step structure.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                        input logic [4:0] s);
    logic [31:0] r;
    case (op)
      2'b00: r = d << s;
      2'b01: r = d >> s;
      2'b10: r = $signed(d) >>> s;
`ifdef SHIFT_SEQ_ROTATE_EN
      default: r = (d >> s) | (d << (6'd32 - {1'b0, s}));
`else
      default: r = d >> s;
`endif
    endcase
    return r;
  endfunction

  // Issue one request, wait (bounded) for its result, compare against the scoreboard,
  // then complete the output handshake.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp_d);
    exp_t e;
    int unsigned cyc;
    @(negedge clock);
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_data = d; in_shamt = s;
    e.data = exp_d;
    e.lat  = $countones(s) + 1;
    sb.push_back(e);
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 12) begin
      chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      @(posedge clock); #1;
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, e.data);
    chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_data_held"}, out_data, e.data);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] rd;
    logic [4:0]  rs;
    int unsigned cyc;

    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_data = '0; in_shamt = '0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
    run_op("sra4",  2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000);
    run_op("srl4",  2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000);
    run_op("srl16", 2'b01, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF);
    run_op("z_sll", 2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678);
    run_op("z_srl", 2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678);
    run_op("z_sra", 2'b10, 32'h1234_5678, 5'd0,  32'h1234_5678);
    run_op("z_op3", 2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678);
`ifdef SHIFT_SEQ_ROTATE_EN
    run_op("op3_4", 2'b11, 32'h0000_00F1, 5'd4,  32'h1000_000F);
    run_op("op3_31", 2'b11, 32'h8000_0001, 5'd31, 32'h0000_0003);
`else
    run_op("op3_4", 2'b11, 32'h0000_00F1, 5'd4,  32'h0000_000F);
    run_op("op3_31", 2'b11, 32'h8000_0001, 5'd31, 32'h0000_0001);
`endif
    run_op("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run_op("sra21", 2'b10, 32'h9000_0000, 5'd21, 32'hFFFF_FC80);

    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom);
      rd  = $urandom;
      rs  = 5'($urandom);
      run_op("rand", rop, rd, rs, model(rop, rd, rs));
    end

    // Back-pressure: result must hold while out_ready is low, new requests ignored.
    @(negedge clock);
    in_valid = 1'b1; in_op = 2'b00; in_data = 32'h0000_0003; in_shamt = 5'd2;
    @(posedge clock); #1;
    in_data = 32'hDEAD_BEEF; in_shamt = 5'd0;
    cyc = 1;
    while (!out_valid && cyc < 12) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("hold_latency", 32'(cyc), 32'd2);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, 32'h0000_000C);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_data", out_data, 32'h0000_000C);

    // Reset during the second shift step aborts the request.
    @(negedge clock);
    in_valid = 1'b1; in_op = 2'b00; in_data = 32'h0000_0001; in_shamt = 5'd31;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    chk("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end
    run_op("post_rst", 2'b00, 32'h0000_0001, 5'd1, 32'h0000_0002);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
